// File: rtl/frogger_pkg.sv
// rtl/frogger_pkg.sv - shared frogger types and screen constants
package frogger_pkg;

    typedef enum logic [1:0] {
        GS_MENU    = 2'd0,
        GS_PLAYING = 2'd1,
        GS_DEAD    = 2'd2,
        GS_WIN     = 2'd3
    } game_state_e;

    typedef enum logic [1:0] {
        FACE_UP    = 2'd0,
        FACE_DOWN  = 2'd1,
        FACE_LEFT  = 2'd2,
        FACE_RIGHT = 2'd3
    } face_dir_e;

    typedef enum logic [1:0] {
        M_IDLE  = 2'd0,
        M_HOP   = 2'd1,
        M_DYING = 2'd2,
        M_OVER  = 2'd3
    } motion_fsm_e;

    localparam int SCREEN_W_DEF = 640;
    localparam int SCREEN_H_DEF = 480;
    // Sprite coordinate width and the wider signed width used for drift math
    localparam int POS_W  = 10;
    localparam int MATH_W = 12;

endpackage

// File: rtl/lane_drift_sel.sv
// rtl/lane_drift_sel.sv - priority select of ride speed from the lowest ridden lane
module lane_drift_sel #(
    parameter int NUM_LANES = 6,
    parameter int SPEED_W   = 10
) (
    input  logic [NUM_LANES*SPEED_W-1:0] lane_speed,
    input  logic [NUM_LANES-1:0]         on_log,
    output logic signed [SPEED_W-1:0]    dx
);

    // Scan from the top lane down so the lowest set on_log bit is the final writer
    always_comb begin
        dx = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (on_log[i]) begin
                dx = lane_speed[i*SPEED_W +: SPEED_W];
            end
        end
    end

endmodule

// File: rtl/frog_motion_ctrl.sv
// rtl/frog_motion_ctrl.sv - frog hop animation, log drift, lives and respawn control
module frog_motion_ctrl
    import frogger_pkg::*;
#(
    parameter int SCREEN_W       = SCREEN_W_DEF,
    parameter int SCREEN_H       = SCREEN_H_DEF,
    parameter int BLOCK          = 32,
    parameter int SPRITE         = 32,
    parameter int INIT_X         = 304,
    parameter int INIT_Y         = 448,
    parameter int NUM_LANES      = 6,
    parameter int SPEED_W        = 10,
    parameter int HOP_FRAMES     = 4,
    parameter int LIVES          = 3,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         frame_tick,
    input  logic [1:0]                   state,
    input  logic                         btn_up_tick,
    input  logic                         btn_down_tick,
    input  logic                         btn_left_tick,
    input  logic                         btn_right_tick,
    input  logic                         collision,
    input  logic [NUM_LANES*SPEED_W-1:0] lane_speed,
    input  logic [NUM_LANES-1:0]         on_log,
    output logic [POS_W-1:0]             pos_x,
    output logic [POS_W-1:0]             pos_y,
    output logic [1:0]                   facing,
    output logic                         hopping,
    output logic                         dying,
    output logic [$clog2(LIVES+1)-1:0]   lives,
    output logic                         game_over
);

    localparam int LW  = $clog2(LIVES + 1);
    localparam int HCW = $clog2(HOP_FRAMES) + 1;
    localparam int RCW = $clog2(RESPAWN_FRAMES) + 1;

    localparam logic signed [MATH_W-1:0] STEP  = MATH_W'(BLOCK / HOP_FRAMES);
    localparam logic signed [MATH_W-1:0] X_MAX = MATH_W'(SCREEN_W - SPRITE);
    localparam logic [MATH_W-1:0] BLOCK_W      = MATH_W'(BLOCK);
    localparam logic [MATH_W-1:0] REACH_W      = MATH_W'(BLOCK + SPRITE);
    localparam logic [MATH_W-1:0] SCR_W_W      = MATH_W'(SCREEN_W);
    localparam logic [MATH_W-1:0] SCR_H_W      = MATH_W'(SCREEN_H);

    motion_fsm_e        fsm_q, fsm_d;
    face_dir_e          facing_q, facing_d;
    face_dir_e          dir_q, dir_d;
    face_dir_e          pend_dir_q, pend_dir_d;
    logic               pend_valid_q, pend_valid_d;
    logic [POS_W-1:0]   pos_x_q, pos_x_d;
    logic [POS_W-1:0]   pos_y_q, pos_y_d;
    logic [HCW-1:0]     hop_cnt_q, hop_cnt_d;
    logic [RCW-1:0]     resp_cnt_q, resp_cnt_d;
    logic [LW-1:0]      lives_q, lives_d;

    logic signed [SPEED_W-1:0] dx;
    logic signed [MATH_W-1:0]  dx_ext;
    logic signed [MATH_W-1:0]  step_x, step_y, x_sum, y_sum;
    logic [MATH_W-1:0]         pos_x_w, pos_y_w;
    logic                      btn_any, req_valid, req_ok;
    face_dir_e                 btn_dir, req_dir;

    lane_drift_sel #(
        .NUM_LANES (NUM_LANES),
        .SPEED_W   (SPEED_W)
    ) u_drift (
        .lane_speed (lane_speed),
        .on_log     (on_log),
        .dx         (dx)
    );

    assign dx_ext  = {{(MATH_W-SPEED_W){dx[SPEED_W-1]}}, dx};
    assign pos_x_w = MATH_W'(pos_x_q);
    assign pos_y_w = MATH_W'(pos_y_q);

    // Button arbitration: up > down > left > right
    always_comb begin
        btn_any = btn_up_tick | btn_down_tick | btn_left_tick | btn_right_tick;
        if (btn_up_tick)        btn_dir = FACE_UP;
        else if (btn_down_tick) btn_dir = FACE_DOWN;
        else if (btn_left_tick) btn_dir = FACE_LEFT;
        else                    btn_dir = FACE_RIGHT;
    end

    // A buffered move takes the place of live buttons; check the hop target stays on screen
    always_comb begin
        req_valid = pend_valid_q | btn_any;
        req_dir   = pend_valid_q ? pend_dir_q : btn_dir;
        case (req_dir)
            FACE_UP:    req_ok = (pos_y_w >= BLOCK_W);
            FACE_DOWN:  req_ok = ((pos_y_w + REACH_W) <= SCR_H_W);
            FACE_LEFT:  req_ok = (pos_x_w >= BLOCK_W);
            FACE_RIGHT: req_ok = ((pos_x_w + REACH_W) <= SCR_W_W);
        endcase
    end

    // Motion FSM next-state: collision first, then move acceptance, hop stepping and drift
    always_comb begin
        fsm_d        = fsm_q;
        facing_d     = facing_q;
        dir_d        = dir_q;
        pend_dir_d   = pend_dir_q;
        pend_valid_d = pend_valid_q;
        pos_x_d      = pos_x_q;
        pos_y_d      = pos_y_q;
        hop_cnt_d    = hop_cnt_q;
        resp_cnt_d   = resp_cnt_q;
        lives_d      = lives_q;
        step_x       = '0;
        step_y       = '0;
        x_sum        = '0;
        y_sum        = '0;

        if (state == GS_MENU) begin
            fsm_d        = M_IDLE;
            facing_d     = FACE_UP;
            dir_d        = FACE_UP;
            pend_dir_d   = FACE_UP;
            pend_valid_d = 1'b0;
            pos_x_d      = POS_W'(INIT_X);
            pos_y_d      = POS_W'(INIT_Y);
            hop_cnt_d    = '0;
            resp_cnt_d   = '0;
            lives_d      = LW'(LIVES);
        end else if (state == GS_PLAYING) begin
            case (fsm_q)
                M_IDLE, M_HOP: begin
                    if (collision) begin
                        lives_d      = lives_q - LW'(1);
                        pend_valid_d = 1'b0;
                        hop_cnt_d    = '0;
                        resp_cnt_d   = '0;
                        fsm_d        = (lives_q <= LW'(1)) ? M_OVER : M_DYING;
                    end else begin
                        if (fsm_q == M_IDLE) begin
                            pend_valid_d = 1'b0;
                            if (req_valid && req_ok) begin
                                facing_d  = req_dir;
                                dir_d     = req_dir;
                                hop_cnt_d = '0;
                                fsm_d     = M_HOP;
                            end
                        end else begin
                            if (btn_any && !pend_valid_q) begin
                                pend_valid_d = 1'b1;
                                pend_dir_d   = btn_dir;
                            end
                            if (frame_tick) begin
                                case (dir_q)
                                    FACE_UP:    step_y = -STEP;
                                    FACE_DOWN:  step_y = STEP;
                                    FACE_LEFT:  step_x = -STEP;
                                    FACE_RIGHT: step_x = STEP;
                                endcase
                                hop_cnt_d = hop_cnt_q + HCW'(1);
                                if (hop_cnt_q == HCW'(HOP_FRAMES - 1)) begin
                                    fsm_d = M_IDLE;
                                end
                            end
                        end
                        if (frame_tick) begin
                            x_sum = $signed(pos_x_w) + step_x + dx_ext;
                            y_sum = $signed(pos_y_w) + step_y;
                            if (x_sum[MATH_W-1]) begin
                                x_sum = '0;
                            end else if (x_sum > X_MAX) begin
                                x_sum = X_MAX;
                            end
                            pos_x_d = POS_W'(x_sum);
                            pos_y_d = POS_W'(y_sum);
                        end
                    end
                end
                M_DYING: begin
                    if (frame_tick) begin
                        if (resp_cnt_q == RCW'(RESPAWN_FRAMES - 1)) begin
                            resp_cnt_d = '0;
                            pos_x_d    = POS_W'(INIT_X);
                            pos_y_d    = POS_W'(INIT_Y);
                            facing_d   = FACE_UP;
                            fsm_d      = M_IDLE;
                        end else begin
                            resp_cnt_d = resp_cnt_q + RCW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State register with asynchronous return to the spawn configuration
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q        <= M_IDLE;
            facing_q     <= FACE_UP;
            dir_q        <= FACE_UP;
            pend_dir_q   <= FACE_UP;
            pend_valid_q <= 1'b0;
            pos_x_q      <= POS_W'(INIT_X);
            pos_y_q      <= POS_W'(INIT_Y);
            hop_cnt_q    <= '0;
            resp_cnt_q   <= '0;
            lives_q      <= LW'(LIVES);
        end else begin
            fsm_q        <= fsm_d;
            facing_q     <= facing_d;
            dir_q        <= dir_d;
            pend_dir_q   <= pend_dir_d;
            pend_valid_q <= pend_valid_d;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            hop_cnt_q    <= hop_cnt_d;
            resp_cnt_q   <= resp_cnt_d;
            lives_q      <= lives_d;
        end
    end

    assign pos_x     = pos_x_q;
    assign pos_y     = pos_y_q;
    assign facing    = facing_q;
    assign hopping   = (fsm_q == M_HOP);
    assign dying     = (fsm_q == M_DYING);
    assign lives     = lives_q;
    assign game_over = (fsm_q == M_OVER);

endmodule

// File: doc/frog_motion_ctrl.md
Name: frog_motion_ctrl

Overview:
Parametrised next-generation player-motion controller for the frogger playfield.
- Accepts button ticks and advances the sprite one grid block per accepted move as a multi-frame hop animation.
- Applies ride drift from any of NUM_LANES log lanes, clamps to the screen, and buffers one pending move.
- Owns the life counter and the death/respawn sequence.
- Sits between the button debouncers/collision logic and the sprite renderer.

Parameters:
SCREEN_W, 640, playfield width in pixels
SCREEN_H, 480, playfield height in pixels
BLOCK, 32, hop distance in pixels; must be divisible by HOP_FRAMES
SPRITE, 32, sprite size in pixels (clamp bound)
INIT_X, 304, spawn x
INIT_Y, 448, spawn y
NUM_LANES, 6, number of rideable lanes
SPEED_W, 10, signed lane-speed width
HOP_FRAMES, 4, frame ticks per hop
LIVES, 3, lives at game start
RESPAWN_FRAMES, 60, frame ticks spent in DYING

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
frame_tick  in  1  one-cycle pulse per video frame; all motion steps on it
state  in  2  game state (MENU=0, PLAYING=1, DEAD=2, WIN=3)
btn_up_tick, btn_down_tick, btn_left_tick, btn_right_tick  in  1 each  one-cycle press pulses
collision  in  1  hazard hit, level sensitive
lane_speed  in  NUM_LANES*SPEED_W  packed signed px/frame; lane i at [i*SPEED_W +: SPEED_W]
on_log  in  NUM_LANES  sprite rides lane i log
pos_x, pos_y  out  10 each  sprite top-left
facing  out  2  UP=0, DOWN=1, LEFT=2, RIGHT=3
hopping  out  1  hop in progress
dying  out  1  in DYING
lives  out  $clog2(LIVES+1)  remaining lives
game_over  out  1  lives exhausted; level, held

Behaviour:
- Reset (async): pos=INIT_X/INIT_Y, facing=UP, lives=LIVES, FSM=IDLE, pending move cleared, counters 0. All other outputs 0.
- Update rule: state≠PLAYING holds everything. state==MENU instead synchronously reinitialises, with values identical to reset.
- FSM states: IDLE, HOP, DYING, OVER.
- IDLE:
  - Button tick accepted if the target stays on screen. Up needs pos_y≥BLOCK; down needs pos_y+BLOCK+SPRITE≤SCREEN_H; left needs pos_x≥BLOCK; right needs pos_x+BLOCK+SPRITE≤SCREEN_W.
  - Simultaneous ticks: priority up>down>left>right.
  - Accepted: facing updates on the same clock, direction latched, hop counter=0, FSM→HOP.
  - Rejected: no change, including facing.
- HOP:
  - Each frame_tick moves pos by BLOCK/HOP_FRAMES in the latched direction and increments the counter.
  - After HOP_FRAMES ticks, FSM→IDLE.
  - One-deep pending buffer: the first button tick during HOP is stored; later ones are dropped.
  - On return to IDLE, a pending move is evaluated exactly as a fresh tick in the next cycle, then cleared.
- Drift:
  - On every frame_tick in IDLE or HOP, dx = lane_speed of the lowest-index set on_log bit, else 0.
  - Sign-extended 12-bit arithmetic: x' = pos_x + hop step + dx.
  - Clamp: x'<0 → 0; x'>SCREEN_W−SPRITE → SCREEN_W−SPRITE. y is never drifted.
- Collision:
  - Sampled in IDLE/HOP; it beats any button or frame_tick in the same cycle.
  - lives decrements. If the result is 0: FSM→OVER, game_over=1. Otherwise: FSM→DYING, pending cleared, counter=0.
- DYING: position frozen, dying=1. After RESPAWN_FRAMES frame_ticks: pos=INIT, facing=UP, FSM→IDLE. collision is ignored throughout.
- OVER: everything frozen until reset or MENU.
- Outputs are registered; pos changes one clk after the frame_tick edge.

Decomposition:
- Shared package frogger_pkg holds:
  - game-state enum (MENU/PLAYING/DEAD/WIN)
  - face_dir enum
  - motion FSM enum
  - screen-size constants
- Sub-module lane_drift_sel: combinational priority select of dx from on_log/lane_speed, parametrised NUM_LANES/SPEED_W. Reused by the log renderer.

Test Plan:
- Reset, state=PLAYING, btn_up tick, then 4 frame_ticks → pos_y 448→440→432→424→416; hopping high for 4 ticks; facing=UP.
- During hop, press right then left → after the hop, a right hop follows; left is dropped; final pos_x=336.
- pos_x=600, on_log[2]=1 with lane2 speed=+5, plus on_log[4]=1 with speed=−3, over 3 frame_ticks → pos_x 605, 608, 608 (clamped at SCREEN_W−SPRITE; lane 2 wins).
- pos_x=2, lane0 speed=−4, frame_tick → pos_x=0. Btn_left at pos_x=16 → rejected; facing unchanged.
- collision coincident with btn_up → lives 3→2, dying=1, no move; after 60 frame_ticks → pos=(304,448), IDLE.
- Third collision → lives=0, game_over=1, ticks ignored; state=MENU → lives=3, game_over=0. Async reset mid-hop → immediate INIT outputs.
